// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// multiply, divide and remainder, wrapped in valid/ready input and output handshakes.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd12;

    // Everything that finishes on the accept edge, including the zero-operand shortcuts.
    function automatic logic [WIDTH-1:0] single_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_ADD:  r = x + y;
            OP_XOR:  r = x ^ y;
            OP_SUB:  r = x - y;
            OP_NOR:  r = ~(x | y);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_MUL:  r = {WIDTH{1'b0}};
            OP_DIVU: r = {WIDTH{1'b1}};
            OP_REMU: r = x;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic needs_calc(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] y
    );
        return ((op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU)) &&
               (y != {WIDTH{1'b0}});
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;

    logic             accept_s;
    logic             iter_s;
    logic             last_s;
    logic [WIDTH-1:0] imm_result_s;
    logic [WIDTH-1:0] mul_acc_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;
    logic             q_bit_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [WIDTH-1:0] quo_nxt_s;
    logic [WIDTH-1:0] calc_result_s;

    assign accept_s     = (state_r == ST_IDLE) & in_valid_i;
    assign iter_s       = needs_calc(ctrl_i, src2_i);
    assign last_s       = (cnt_r == {CNT_W{1'b0}});
    assign imm_result_s = single_op(ctrl_i, src1_i, src2_i);

    // a_r holds the multiplier (MUL) or the dividend shifting into the quotient (DIVU/REMU);
    // b_r holds the shifting multiplicand or the fixed divisor; p_r is the accumulator/remainder.
    assign mul_acc_s = p_r + (a_r[0] ? b_r : {WIDTH{1'b0}});
    assign rem_sh_s  = {p_r, a_r[WIDTH-1]};
    assign trial_s   = rem_sh_s - {1'b0, b_r};
    assign q_bit_s   = ~trial_s[WIDTH];
    assign rem_nxt_s = q_bit_s ? trial_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
    assign quo_nxt_s = {a_r[WIDTH-2:0], q_bit_s};

    // Select the iterative result produced by the final CALC step.
    always_comb begin
        calc_result_s = {WIDTH{1'b0}};
        case (op_r)
            OP_MUL:  calc_result_s = mul_acc_s;
            OP_DIVU: calc_result_s = quo_nxt_s;
            OP_REMU: calc_result_s = rem_nxt_s;
            default: calc_result_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state and iteration-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid_i) begin
                    if (iter_s) begin
                        state_nxt_s = ST_CALC;
                        cnt_nxt_s   = CNT_W'(WIDTH - 1);
                    end else begin
                        state_nxt_s = ST_DONE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_CALC: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_CALC;
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state; handshake flags are registered from the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand capture on accept and one shift-add / restoring-divide step per CALC cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_r <= 4'd0;
            a_r  <= {WIDTH{1'b0}};
            b_r  <= {WIDTH{1'b0}};
            p_r  <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            op_r <= ctrl_i;
            p_r  <= {WIDTH{1'b0}};
            if (ctrl_i == OP_MUL) begin
                a_r <= src2_i;
                b_r <= src1_i;
            end else begin
                a_r <= src1_i;
                b_r <= src2_i;
            end
        end else if (state_r == ST_CALC) begin
            if (op_r == OP_MUL) begin
                p_r <= mul_acc_s;
                a_r <= {1'b0, a_r[WIDTH-1:1]};
                b_r <= {b_r[WIDTH-2:0], 1'b0};
            end else begin
                p_r <= rem_nxt_s;
                a_r <= quo_nxt_s;
            end
        end else begin
            op_r <= op_r;
            a_r  <= a_r;
            b_r  <= b_r;
            p_r  <= p_r;
        end
    end

    // Result and zero flag change only on DONE entry, so they stay stable until consumed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else if (accept_s && !iter_s) begin
            result_r <= imm_result_s;
            zero_r   <= (imm_result_s == {WIDTH{1'b0}});
        end else if ((state_r == ST_CALC) && last_s) begin
            result_r <= calc_result_s;
            zero_r   <= (calc_result_s == {WIDTH{1'b0}});
        end else begin
            result_r <= result_r;
            zero_r   <= zero_r;
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign result_o    = result_r;
    assign zero_o      = zero_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [3:0]  SOPS [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd12};
    localparam logic [31:0] SEXP [6] = '{32'h3, 32'hF, 32'h12, 32'hC, 32'hC, 32'hFFFFFFF0};

    localparam logic [3:0]  MOPS [6] = '{4'd8, 4'd8, 4'd9, 4'd10, 4'd9, 4'd10};
    localparam logic [31:0] MSA  [6] = '{32'h00010001, 32'd7, 32'd100, 32'd100, 32'd5, 32'd5};
    localparam logic [31:0] MSB  [6] = '{32'h00010001, 32'd0, 32'd7, 32'd7, 32'd0, 32'd0};
    localparam logic [31:0] MEXP [6] = '{32'h00020001, 32'd0, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};
    localparam int          MLAT [6] = '{33, 1, 33, 33, 1, 1};

    logic         clk;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic [3:0]   ctrl_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] result_o;
    logic         zero_o;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .ctrl_i      (ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd6:  return a - b;
            4'd12: return ~(a | b);
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            4'd9:  return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            4'd10: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        return ((op == 4'd8 || op == 4'd9 || op == 4'd10) && b != 32'd0) ? W + 1 : 1;
    endfunction

    // Issue one operation from IDLE, count cycles to out_valid, then consume the result.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat);
        ctrl_i = op; src1_i = a; src2_i = b; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0; src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'($urandom_range(0, 15));
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_o; z = zero_o;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        src1_i = 32'd0; src2_i = 32'd0; ctrl_i = 4'd0;
        #12;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
        checks++; if (zero_o !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero_o); end
        rst_i = 1'b1;
        @(posedge clk); #1;
        ctrl_i = 4'd2; src1_i = 32'd3; src2_i = 32'd4; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        checks++; if (result_o !== 32'd7) begin errors++; $display("FAIL pre_reset_add: got %h want 7", result_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid: got %b want 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready: got %b want 1", in_ready_o); end
        checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL async_reset_result: got %h want 0", result_o); end
        checks++; if (zero_o !== 1'b1) begin errors++; $display("FAIL async_reset_zero: got %b want 1", zero_o); end
        #1 rst_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", out_valid_o); end
    endtask

    task automatic test_single_ops();
        logic [31:0] r; logic z; int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(SOPS[i], 32'h0000000F, 32'h00000003, r, z, lat);
            checks++; if (r !== SEXP[i]) begin errors++; $display("FAIL single_op%0d_result: got %h want %h", SOPS[i], r, SEXP[i]); end
            checks++; if (lat != 1) begin errors++; $display("FAIL single_op%0d_latency: got %0d want 1", SOPS[i], lat); end
            checks++; if (z !== 1'b0) begin errors++; $display("FAIL single_op%0d_zero: got %b want 0", SOPS[i], z); end
        end
        run_op(4'd6, 32'd5, 32'd5, r, z, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL sub_zero_result: got %h want 0", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL sub_zero_flag: got %b want 1", z); end
        run_op(4'd7, 32'hFFFFFFFF, 32'd1, r, z, lat);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL slt_signed: got %h want 1", r); end
        run_op(4'd5, 32'hFFFFFFFF, 32'd1, r, z, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL sltu_unsigned: got %h want 0", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL sltu_zero: got %b want 1", z); end
    endtask

    task automatic test_mul_div();
        logic [31:0] r; logic z; int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(MOPS[i], MSA[i], MSB[i], r, z, lat);
            checks++; if (r !== MEXP[i]) begin errors++; $display("FAIL muldiv%0d_result: got %h want %h", i, r, MEXP[i]); end
            checks++; if (lat != MLAT[i]) begin errors++; $display("FAIL muldiv%0d_latency: got %0d want %0d", i, lat, MLAT[i]); end
        end
    endtask

    task automatic test_random_ops();
        logic [31:0] a, b, r, e; logic [3:0] op; logic z; int lat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = $urandom >> $urandom_range(0, 31);
                3: b = a;
                default: b = $urandom;
            endcase
            e = ref_alu(op, a, b);
            run_op(op, a, b, r, z, lat);
            checks++; if (r !== e) begin errors++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h want %h", op, a, b, r, e); end
            checks++; if (z !== (e == 32'd0)) begin errors++; $display("FAIL rand_zero op=%0d: got %b want %b", op, z, (e == 32'd0)); end
            checks++; if (lat != ref_lat(op, b)) begin errors++; $display("FAIL rand_latency op=%0d b=%h: got %0d want %0d", op, b, lat, ref_lat(op, b)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, e;
        a = $urandom; b = $urandom; e = ref_alu(4'd2, a, b);
        ctrl_i = 4'd2; src1_i = a; src2_i = b; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_enter_done: got %b want 1", out_valid_o); end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                ctrl_i = 4'd6; src1_i = ~a; src2_i = $urandom; in_valid_i = 1'b1;
            end else begin
                in_valid_i = 1'b0;
            end
            @(posedge clk); #1;
            checks++; if (result_o !== e) begin errors++; $display("FAIL bp_result_stable cyc%0d: got %h want %h", i, result_o, e); end
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, in_ready_o); end
            checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc%0d: got %b want 1", i, out_valid_o); end
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready_o); end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_pulse_ignored: got %b want 0", out_valid_o); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] a, b, r; logic z; int lat; bit seen;
        ctrl_i = 4'd8; src1_i = 32'h00010001; src2_i = 32'h00010001; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", in_ready_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b want 1", in_ready_o); end
        checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL abort_result: got %h want 0", result_o); end
        checks++; if (zero_o !== 1'b1) begin errors++; $display("FAIL abort_zero: got %b want 1", zero_o); end
        #1 rst_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b want 0", seen); end
        a = $urandom; b = $urandom;
        run_op(4'd2, a, b, r, z, lat);
        checks++; if (r !== ref_alu(4'd2, a, b)) begin errors++; $display("FAIL abort_next_add: got %h want %h", r, ref_alu(4'd2, a, b)); end
        checks++; if (lat != 1) begin errors++; $display("FAIL abort_next_latency: got %0d want 1", lat); end
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready_i = 1'b1; in_valid_i = 1'b1;
        ctrl_i = 4'd2; src1_i = $urandom; src2_i = $urandom;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready_o) n++;
            @(posedge clk); #1;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL b2b_single_accepts: got %0d want 10", n); end
        ctrl_i = 4'd8; src1_i = 32'h1234567; src2_i = 32'h89ABCDE;
        n = 0;
        for (int i = 0; i < 2 * (W + 2); i++) begin
            if (in_ready_o) n++;
            @(posedge clk); #1;
        end
        checks++; if (n != 2) begin errors++; $display("FAIL b2b_iter_accepts: got %0d want 2", n); end
        in_valid_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        out_ready_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_ops();
        test_mul_div();
        test_random_ops();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the multi-cycle CPU datapath. It keeps the single-cycle logic operations and adds iterative unsigned multiply, divide and remainder. Operands enter through a valid/ready input handshake; the result leaves through a valid/ready output handshake and is held until consumed. The block sits between the ID/EX operand registers and the EX/MEM stage, and stalls the pipeline through `in_ready_o`.

## Interface
- `WIDTH`, 32: operand and result width; minimum 4.
- `CNT_W`, $clog2(WIDTH+1): width of the iteration counter.

- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset; asynchronous, active-low.
- `in_valid_i` in 1: `src1_i`, `src2_i` and `ctrl_i` are valid.
- `in_ready_o` out 1: block accepts a new operation.
- `src1_i` in WIDTH: operand A.
- `src2_i` in WIDTH: operand B.
- `ctrl_i` in 4: operation code.
- `out_valid_o` out 1: `result_o` and `zero_o` are valid.
- `out_ready_i` in 1: consumer takes the result.
- `result_o` out WIDTH: result.
- `zero_o` out 1: high when `result_o` is 0.

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB, 12 NOR.
  - 7 SLT: signed compare, result is 1 or 0.
  - 5 SLTU: unsigned compare, result is 1 or 0.
  - 8 MUL: low WIDTH bits of the unsigned product.
  - 9 DIVU: unsigned quotient.
  - 10 REMU: unsigned remainder.
  - Any other code returns 0.
- ADD, SUB and MUL wrap modulo 2^WIDTH; no overflow flag.
- FSM states: IDLE, CALC, DONE.
  - IDLE: `in_ready_o`=1. When `in_valid_i` is high, the operands and opcode are latched.
    - Opcodes 8, 9, 10 with nonzero divisor or multiplier go to CALC.
    - Everything else is computed in that same cycle and the state goes to DONE.
  - CALC: one iteration per cycle; the counter runs WIDTH-1 down to 0. When the count reaches 0, go to DONE.
    - MUL: shift-add, LSB-first over the multiplier.
    - DIVU/REMU: restoring division, MSB-first, with a WIDTH+1-bit partial remainder.
  - DONE: `out_valid_o`=1. When `out_ready_i` is high, go to IDLE.
    - No new operation is accepted in DONE: `in_ready_o`=0, no back-to-back overlap.
- Shortcuts, taken without entering CALC:
  - MUL with `src2_i`=0: result is 0.
  - DIVU by 0: quotient is all ones.
  - REMU by 0: remainder equals `src1_i`.
- `zero_o` is registered together with `result_o`.
- `result_o` holds its last value outside DONE. It is stable from the DONE entry until the handshake completes.
- Inputs are sampled only on the accepting edge; later input changes have no effect.

## Timing
- Reset values: state IDLE, `in_ready_o`=1, `out_valid_o`=0, `result_o`=0, `zero_o`=1, counter 0.
- Latency is counted from the accept edge to the first cycle with `out_valid_o`=1:
  - Single-cycle opcodes and shortcuts: 1 cycle.
  - MUL, DIVU, REMU through CALC: WIDTH+1 cycles.
- Throughput with `out_ready_i` tied high: one single-cycle op every 2 cycles; one iterative op every WIDTH+2 cycles.
- Output backpressure: DONE holds indefinitely while `out_ready_i`=0.
- Reset asserted mid-CALC or in DONE: immediately return to reset values. The in-flight operation is lost and no `out_valid_o` pulse is produced.
- `in_valid_i` high while `in_ready_o`=0: ignored. The upstream stage must hold its data.
- `out_ready_i` high outside DONE: no effect.

## Test plan
- Reset check: drive `rst_i` low asynchronously between clock edges. Outputs must take their reset values before the next edge.
- Single-cycle ops: WIDTH=32, src1=0x0000000F, src2=0x00000003.
  - AND gives 0x3, OR gives 0xF, ADD gives 0x12, XOR gives 0xC.
  - SUB gives 0xC, NOR gives 0xFFFFFFF0.
  - Each result appears 1 cycle after accept.
  - SUB of 5-5 gives 0 with `zero_o`=1.
- Signed vs unsigned compare: src1=0xFFFFFFFF, src2=1. SLT gives 1, SLTU gives 0.
- MUL: 0x00010001 × 0x00010001 gives 0x00020001, with `out_valid_o` exactly 33 cycles after accept. MUL 7×0 gives 0 after 1 cycle.
- Divide:
  - DIVU 100/7 gives 14 and REMU gives 2, each after 33 cycles.
  - DIVU 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5, each after 1 cycle.
- Handshake and reset abort:
  - Hold `out_ready_i`=0 for 10 cycles in DONE. `result_o` must stay stable, `in_ready_o` stay 0, and a pulsed `in_valid_i` be ignored.
  - Assert reset at CALC cycle 10 of a MUL. No `out_valid_o` may appear, and the next ADD must complete normally.
